// File: rtl/bbqm_pkg.sv
// Bank queue manager shared constants.
// Count widths and ROM address width used by this stage and the ROM.
package bbqm_pkg;

  localparam int PCOUNT_W = 3;
  localparam int TCOUNT_W = 2;
  localparam int ADDR_W   = PCOUNT_W + TCOUNT_W;

  typedef logic [PCOUNT_W-1:0] pcount_t;
  typedef logic [TCOUNT_W-1:0] tcount_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  localparam pcount_t PMAX = '1;

endpackage

// File: rtl/bbqm_sensor_cond.sv
// Photocell conditioning: synchronizer, debounce filter and
// a registered single-cycle pulse on each filtered rising edge.
module bbqm_sensor_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic evt_o
);

  localparam int CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q;
  logic                   evt_q;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  // The counter tracks how long lvl has disagreed with filt_q.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (lvl != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      evt_q       <= filt_q & ~filt_prev_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/bbqm_queue_counter.sv
// Queue occupancy counter feeding the waiting-time ROM address,
// with full/empty status and overflow/underflow error pulses.
module bbqm_queue_counter
  import bbqm_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                photocell_front,
  input  logic                photocell_back,
  input  logic [TCOUNT_W-1:0] tcount_in,
  output logic [PCOUNT_W-1:0] pcount,
  output logic [TCOUNT_W-1:0] tcount,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                full,
  output logic                empty,
  output logic                err_overflow,
  output logic                err_underflow
);

  logic    enter_evt, leave_evt;
  pcount_t pcount_q, pcount_d;
  tcount_t tcount_q;
  addr_t   rom_addr_q;
  logic    full_q, empty_q;
  logic    ovf_q, ovf_d;
  logic    unf_q, unf_d;

  bbqm_sensor_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_front (
    .clk  (clk),
    .rst  (rst),
    .raw_i(photocell_front),
    .evt_o(enter_evt)
  );

  bbqm_sensor_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_back (
    .clk  (clk),
    .rst  (rst),
    .raw_i(photocell_back),
    .evt_o(leave_evt)
  );

  // Simultaneous enter and leave cancel out via the default arm.
  always_comb begin
    pcount_d = pcount_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    unique case (1'b1)
      enter_evt && !leave_evt: begin
        if (pcount_q == PMAX) ovf_d = 1'b1;
        else pcount_d = pcount_q + 1'b1;
      end
      leave_evt && !enter_evt: begin
        if (pcount_q == '0) unf_d = 1'b1;
        else pcount_d = pcount_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Status and address are built from next state to stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount_q   <= '0;
      tcount_q   <= '0;
      rom_addr_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pcount_q   <= pcount_d;
      tcount_q   <= tcount_in;
      rom_addr_q <= {tcount_in, pcount_d};
      full_q     <= (pcount_d == PMAX);
      empty_q    <= (pcount_d == '0);
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign pcount        = pcount_q;
  assign tcount        = tcount_q;
  assign rom_addr      = rom_addr_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_bbqm_queue_counter.sv
// Scoreboard bench for bbqm_queue_counter: stimulus pushes expected
// outputs from a sample-window reference model; a monitor pops them.
module tb_bbqm_queue_counter;
  import bbqm_pkg::*;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pf  = 1'b0;
  logic       pb  = 1'b0;
  logic [1:0] tin = 2'd0;
  logic [2:0] pcount;
  logic [1:0] tcount;
  logic [4:0] rom_addr;
  logic       full, empty, eo, eu;

  always #5 clk = ~clk;

  bbqm_queue_counter #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .photocell_front(pf),
    .photocell_back (pb),
    .tcount_in      (tin),
    .pcount         (pcount),
    .tcount         (tcount),
    .rom_addr       (rom_addr),
    .full           (full),
    .empty          (empty),
    .err_overflow   (eo),
    .err_underflow  (eu)
  );

  typedef struct packed {
    logic [2:0] pc;
    logic [1:0] tc;
    logic [4:0] ra;
    logic       fu;
    logic       em;
    logic       ov;
    logic       un;
  } obs_t;

  obs_t exp_q[$];
  int   npass = 0;
  int   ntot  = 0;

  // Reference state: raw samples since reset, and the
  // edge index at which each filtered level rose.
  bit rf[$], rb[$], ef[$], eb[$];
  bit ff = 1'b0, fb = 1'b0;
  int mpc = 0;

  // A filtered level flips once the last D samples, seen
  // through S stages of delay, all disagree with it.
  function automatic bit settled(input bit back, input bit cur,
                                 input int k);
    bit s;
    for (int j = k - S - D + 1; j <= k - S; j++) begin
      if (j < 0) s = 1'b0;
      else s = back ? rb[j] : rf[j];
      if (s == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit f, input bit b,
                      input logic [1:0] t, input bit r);
    obs_t e;
    bit   en, lv;
    int   k;
    @(negedge clk);
    pf  = f;
    pb  = b;
    tin = t;
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      ntot++;
      if (pcount == 3'd0 && empty && rom_addr == 5'd0) npass++;
      else $display("FAIL async_reset pc=%0d em=%b ra=%b exp 0/1/0",
                    pcount, empty, rom_addr);
    end else begin
      rst = r;
    end
    e = '0;
    if (r) begin
      rf.delete(); rb.delete(); ef.delete(); eb.delete();
      ff = 1'b0; fb = 1'b0; mpc = 0;
      e.em = 1'b1;
    end else begin
      rf.push_back(f);
      rb.push_back(b);
      ef.push_back(1'b0);
      eb.push_back(1'b0);
      k = rf.size() - 1;
      if (settled(1'b0, ff, k)) begin ff = !ff; ef[k] = ff; end
      if (settled(1'b1, fb, k)) begin fb = !fb; eb[k] = fb; end
      en = (k >= 2) ? ef[k-2] : 1'b0;
      lv = (k >= 2) ? eb[k-2] : 1'b0;
      if (en && !lv) begin
        if (mpc == 7) e.ov = 1'b1;
        else mpc++;
      end else if (lv && !en) begin
        if (mpc == 0) e.un = 1'b1;
        else mpc--;
      end
      e.pc = 3'(mpc);
      e.tc = t;
      e.ra = {t, 3'(mpc)};
      e.fu = (mpc == 7);
      e.em = (mpc == 0);
    end
    exp_q.push_back(e);
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.pc = pcount; a.tc = tcount; a.ra = rom_addr;
        a.fu = full;   a.em = empty;
        a.ov = eo;     a.un = eu;
        ntot++;
        if (a == e) npass++;
        else $display({"FAIL outputs t=%0t got pc=%0d tc=%0d ra=%b ",
                       "fu=%b em=%b ov=%b un=%b exp pc=%0d tc=%0d ",
                       "ra=%b fu=%b em=%b ov=%b un=%b"},
                      $time, a.pc, a.tc, a.ra, a.fu, a.em, a.ov, a.un,
                      e.pc, e.tc, e.ra, e.fu, e.em, e.ov, e.un);
      end
    end
  end

  task automatic pulse(input bit f, input bit b, input logic [1:0] t);
    repeat (6) step(f, b, t, 1'b0);
    repeat (8) step(1'b0, 1'b0, t, 1'b0);
  endtask

  // Edges from the first high sample until pcount leaves 'from'.
  task automatic measure(input int exp_lat, input logic [2:0] from,
                         input logic [1:0] t, input string nm);
    int lat;
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      step(i <= 10, 1'b0, t, 1'b0);
      @(posedge clk);
      #2;
      if (lat < 0 && pcount != from) lat = i - 1;
    end
    ntot++;
    if (lat == exp_lat) npass++;
    else $display("FAIL %s latency got %0d edges exp %0d",
                  nm, lat, exp_lat);
  endtask

  initial begin
    int         lf, lb;
    bit         vf, vb, tied;
    logic [1:0] t;
    repeat (3) step(1'b0, 1'b0, 2'd2, 1'b1);
    repeat (3) step(1'b0, 1'b0, 2'd2, 1'b0);
    measure(7, 3'd0, 2'd2, "single_enter");

    repeat (8) pulse(1'b1, 1'b0, 2'd3);
    repeat (8) pulse(1'b0, 1'b1, 2'd3);

    repeat (3) step(1'b1, 1'b0, 2'd1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 2'd1, 1'b0);
    pulse(1'b1, 1'b1, 2'd1);
    repeat (4) pulse(1'b1, 1'b0, 2'd1);
    pulse(1'b1, 1'b1, 2'd1);
    repeat (3) pulse(1'b1, 1'b0, 2'd1);
    pulse(1'b1, 1'b1, 2'd1);

    repeat (2) pulse(1'b0, 1'b1, 2'd0);
    repeat (3) step(1'b1, 1'b0, 2'd0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 2'd0, 1'b1);
    measure(7, 3'd0, 2'd0, "reset_release");

    lf = 0; lb = 0; vf = 1'b0; vb = 1'b0; tied = 1'b0; t = 2'd1;
    for (int c = 0; c < 1500; c++) begin
      if (lf == 0) begin
        vf   = 1'($urandom_range(0, 1));
        lf   = int'($urandom_range(1, 12));
        tied = ($urandom_range(0, 3) == 0);
      end
      if (!tied && lb == 0) begin
        vb = 1'($urandom_range(0, 1));
        lb = int'($urandom_range(1, 12));
      end
      if (tied) vb = vf;
      if (c % 200 == 0) t = 2'($urandom_range(0, 3));
      step(vf, vb, t, ($urandom_range(0, 499) == 0));
      lf--;
      if (!tied && lb > 0) lb--;
    end

    repeat (3) step(1'b0, 1'b0, t, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    ntot++;
    if (exp_q.size() == 0) npass++;
    else $display("FAIL drain left=%0d exp 0", exp_q.size());
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
